dispatch_demux1x4: RTL and testbench
====================================

DISPATCH_DEMUX1X4 -- requirements
Module: dispatch_demux1x4

Interface
REQ-001 Parameter: WIDTH, 32, data width of input and every output port.
REQ-002 Parameter: CNTW, 8, width of each per-port delivery counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 indata  input  WIDTH  input word.
REQ-006 control  input  2  destination select: 0->out1, 1->out2, 2->out3, 3->out4.
REQ-007 in_valid  input  1  indata/control valid.
REQ-008 in_ready  output  1  block can accept the word at the selected port this cycle.
REQ-009 out1, out2, out3, out4  output  WIDTH each  per-port registered data.
REQ-010 out_valid  output  4  bit k-1 = outk holds an undelivered word.
REQ-011 out_ready  input  4  bit k-1 = consumer of outk accepts this cycle.
REQ-012 cnt1, cnt2, cnt3, cnt4  output  CNTW each  words delivered on each port.
REQ-013 busy  output  1  OR of all out_valid bits.

Function
REQ-014 in_fire = in_valid & in_ready; port fire k = out_valid[k-1] & out_ready[k-1].
REQ-015 Each port has a one-entry holding register (data plus valid flag), states EMPTY/FULL.
REQ-016 in_ready = (selected port EMPTY) | (selected port FULL & its out_ready high); combinational from control, slot state and out_ready, independent of in_valid.
REQ-017 On in_fire, selected port's register loads indata at the next edge and goes FULL; latency exactly 1 cycle.
REQ-018 Only the port named by control is written on a given cycle; the other three ports keep data and valid.
REQ-019 Port fire with no load on that port: FULL->EMPTY at next edge; outk data retained (value not required to clear).
REQ-020 Simultaneous port fire and in_fire to the same port: port stays FULL with the new word; no bubble, no loss, no duplication.
REQ-021 While FULL and out_ready low, outk and out_valid bit remain stable every cycle.
REQ-022 in_valid low: control and indata ignored; no state change except port fires.
REQ-023 in_valid high and in_ready low: no state change to the selected port; upstream holds the word.
REQ-024 cntk increments by 1 on each port-k fire; wraps 2^CNTW-1 -> 0 with no flag.
REQ-025 Multiple ports may fire in the same cycle; each counter updates independently.
REQ-026 busy is combinational from out_valid.

Reset
REQ-027 reset_n low at an edge: all out_valid 0, out1..out4 0, cnt1..cnt4 0; in_ready evaluates to 1 for any control the following cycle.
REQ-028 Reset mid-operation discards all held words; no port fire is counted in a reset cycle.
REQ-029 reset_n has priority over in_fire and port fires in the same cycle.

Verification
REQ-030 Route: reset, out_ready=4'b1111; send indata 1,2,3,4 with control 0,1,2,3 on consecutive cycles -> out1=1,out2=2,out3=3,out4=4 each valid one cycle after acceptance; cnt1..cnt4=1.
REQ-031 Backpressure: out_ready=0, send 0xA5 to control 2 -> out3=0xA5 held; second word 0x5A to control 2 sees in_ready=0 for 10 cycles with out3 stable; raise out_ready[2] -> 0x5A accepted same cycle, out3=0x5A next cycle, cnt3=1.
REQ-032 Isolation: port 1 FULL and stalled; send 7 to control 3 -> accepted immediately, out4=7, out1 unchanged.
REQ-033 Streaming: out_ready[0]=1, in_valid=1, control=0 for 300 cycles with incrementing data -> in_ready constantly 1, out1 tracks data with 1-cycle lag, cnt1 wraps to 299 mod 256 = 43 one cycle after the last accept (i.e., counts 299 delivered after last fire cycle).
REQ-034 Reset mid-operation: ports 2 and 4 FULL, drive reset_n=0 one cycle -> out_valid=0, out2=out4=0, cnt all 0, busy=0.
REQ-035 Bench checks every case with case-equality compares and reports a named error per failing case.

Source files
------------

// File: rtl/dispatch_demux1x4.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_demux1x4
// Description : 1-to-4 dispatch demultiplexer with one-entry registered
//               holding slot per output port and per-port delivery counters.
//               A word on indata is steered to the port selected by control.
//               Each port slot is an EMPTY/FULL state machine. A FULL slot
//               whose consumer is ready can be refilled in the same cycle,
//               so a port can stream one word per cycle with no bubble.
// Ports       : clk        - single clock, rising edge
//               reset_n    - synchronous active-low reset
//               indata     - input word (WIDTH)
//               control    - destination select, 0..3 -> out1..out4
//               in_valid   - indata/control valid
//               in_ready   - selected port can take the word this cycle
//               out1..out4 - per-port registered data (WIDTH)
//               out_valid  - bit k-1 set when outk holds an undelivered word
//               out_ready  - bit k-1 set when consumer of outk accepts
//               cnt1..cnt4 - per-port delivered-word counters (CNTW, wrap)
//               busy       - any port holds an undelivered word
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_demux1x4 #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] indata,
    input  logic [1:0]       control,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNTW-1:0]  cnt1,
    output logic [CNTW-1:0]  cnt2,
    output logic [CNTW-1:0]  cnt3,
    output logic [CNTW-1:0]  cnt4,
    output logic             busy
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [3:0]       w_full;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_dout [4];
    logic [CNTW-1:0]  w_cnt  [4];

    // The selected slot can take a word if it is empty, or if it is full but
    // its word leaves this very cycle. Deliberately independent of in_valid.
    assign in_ready  = ~w_full[control] | out_ready[control];
    assign w_in_fire = in_valid & in_ready;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_port
            logic [0:0]       r_state;
            logic [0:0]       w_state_nxt;
            logic             w_valid;
            logic             w_load;
            logic             w_pfire;
            logic [WIDTH-1:0] r_data;
            logic [CNTW-1:0]  r_cnt;

            // Only the port named by control is ever written.
            assign w_load  = w_in_fire & (control == 2'(k));
            assign w_pfire = w_valid & out_ready[k];

            // State register
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_state <= ST_EMPTY;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // Next-state logic: a load wins over a drain, so a simultaneous
            // drain and refill keeps the slot FULL with the new word.
            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_load) begin
                            w_state_nxt = ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (w_pfire && !w_load) begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                    default: w_state_nxt = ST_EMPTY;
                endcase
            end

            // Output logic
            always_comb begin
                w_valid = (r_state == ST_FULL);
            end

            // Data is only written on a load; a drain leaves the last word
            // visible on the port.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_data <= '0;
                end else if (w_load) begin
                    r_data <= indata;
                end
            end

            // Delivered-word counter, free-running wrap.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (w_pfire) begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end

            assign w_full[k]    = w_valid;
            assign out_valid[k] = w_valid;
            assign w_dout[k]    = r_data;
            assign w_cnt[k]     = r_cnt;
        end
    endgenerate

    assign out1 = w_dout[0];
    assign out2 = w_dout[1];
    assign out3 = w_dout[2];
    assign out4 = w_dout[3];

    assign cnt1 = w_cnt[0];
    assign cnt2 = w_cnt[1];
    assign cnt3 = w_cnt[2];
    assign cnt4 = w_cnt[3];

    assign busy = |out_valid;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_demux1x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_demux1x4
// Description : Self-checking bench for dispatch_demux1x4. Directed scenarios
//               plus a randomized run, all checked against a port-occupancy
//               reference model (held word, full flag, delivered count).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_demux1x4;

    localparam int WIDTH = 32;
    localparam int CNTW  = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] indata;
    logic [1:0]       control;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1, out2, out3, out4;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [CNTW-1:0]  cnt1, cnt2, cnt3, cnt4;
    logic             busy;

    always #5 clk = ~clk;

    dispatch_demux1x4 #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .indata    (indata),
        .control   (control),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3),
        .cnt4      (cnt4),
        .busy      (busy)
    );

    logic [WIDTH-1:0] dout [4];
    logic [CNTW-1:0]  dcnt [4];
    assign dout[0] = out1;
    assign dout[1] = out2;
    assign dout[2] = out3;
    assign dout[3] = out4;
    assign dcnt[0] = cnt1;
    assign dcnt[1] = cnt2;
    assign dcnt[2] = cnt3;
    assign dcnt[3] = cnt4;

    // Reference model: what each port holds and how many words it delivered.
    bit               m_full [4];
    logic [WIDTH-1:0] m_data [4];
    int               m_cnt  [4];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic set_in(input logic v, input logic [1:0] c, input logic [WIDTH-1:0] d,
                          input logic [3:0] r, input logic rn);
        in_valid  = v;
        control   = c;
        indata    = d;
        out_ready = r;
        reset_n   = rn;
        #1;
    endtask

    // Advance the model with the inputs currently applied, then clock.
    task automatic tick();
        bit acc;
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 1'b0;
                m_data[k] = '0;
                m_cnt[k]  = 0;
            end
        end else begin
            acc = in_valid && (!m_full[control] || out_ready[control]);
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] && out_ready[k]) begin
                    m_cnt[k]  = m_cnt[k] + 1;
                    m_full[k] = 1'b0;
                end
            end
            if (acc) begin
                m_full[control] = 1'b1;
                m_data[control] = indata;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, 2'd0, '0, 4'b0000, 1'b0);
        tick();
        set_in(1'b0, 2'd0, '0, 4'b0000, 1'b1);
    endtask

    task automatic test_reset();
        set_in(1'b1, 2'd2, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        tick();
        tick();
        set_in(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        n_checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            $display("FAIL reset valid: out_valid=%b busy=%b, want 0000/0", out_valid, busy);
        end else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dout[k] !== '0 || dcnt[k] !== '0) begin
                $display("FAIL reset port%0d: data=%h cnt=%0d, want 0/0", k + 1, dout[k], dcnt[k]);
            end else n_pass++;
        end
        for (int c = 0; c < 4; c++) begin
            set_in(1'b0, 2'(c), '0, 4'b0000, 1'b1);
            n_checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL reset in_ready ctl=%0d: got %b want 1", c, in_ready);
            end else n_pass++;
        end
    endtask

    task automatic test_route();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 2'(i), WIDTH'(i + 1), 4'b1111, 1'b1);
            n_checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL route in_ready ctl=%0d: got %b want 1", i, in_ready);
            end else n_pass++;
            tick();
            n_checks++;
            if (out_valid[i] !== 1'b1 || dout[i] !== WIDTH'(i + 1)) begin
                $display("FAIL route out%0d: valid=%b data=%h, want 1/%h", i + 1, out_valid[i], dout[i], i + 1);
            end else n_pass++;
        end
        set_in(1'b0, 2'd0, '0, 4'b1111, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dcnt[k] !== 8'd1) begin
                $display("FAIL route cnt%0d: got %0d want 1", k + 1, dcnt[k]);
            end else n_pass++;
        end
        n_checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            $display("FAIL route drained: out_valid=%b busy=%b want 0000/0", out_valid, busy);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_in(1'b1, 2'd2, 32'hA5, 4'b0000, 1'b1);
        tick();
        n_checks++;
        if (out3 !== 32'hA5 || out_valid !== 4'b0100 || busy !== 1'b1) begin
            $display("FAIL bp first: out3=%h valid=%b busy=%b want a5/0100/1", out3, out_valid, busy);
        end else n_pass++;
        set_in(1'b1, 2'd2, 32'h5A, 4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                $display("FAIL bp stall in_ready cyc%0d: got %b want 0", i, in_ready);
            end else n_pass++;
            tick();
            n_checks++;
            if (out3 !== 32'hA5 || out_valid[2] !== 1'b1) begin
                $display("FAIL bp stall hold cyc%0d: out3=%h valid=%b want a5/1", i, out3, out_valid[2]);
            end else n_pass++;
        end
        set_in(1'b1, 2'd2, 32'h5A, 4'b0100, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp release in_ready: got %b want 1", in_ready);
        end else n_pass++;
        tick();
        n_checks++;
        if (out3 !== 32'h5A || out_valid[2] !== 1'b1 || cnt3 !== 8'd1) begin
            $display("FAIL bp release: out3=%h valid=%b cnt3=%0d want 5a/1/1", out3, out_valid[2], cnt3);
        end else n_pass++;
        set_in(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        tick();
    endtask

    task automatic test_isolation();
        do_reset();
        set_in(1'b1, 2'd0, 32'h11, 4'b0000, 1'b1);
        tick();
        set_in(1'b1, 2'd3, 32'h7, 4'b0000, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL iso in_ready: got %b want 1", in_ready);
        end else n_pass++;
        tick();
        n_checks++;
        if (out4 !== 32'h7 || out1 !== 32'h11 || out_valid !== 4'b1001) begin
            $display("FAIL iso ports: out4=%h out1=%h valid=%b want 7/11/1001", out4, out1, out_valid);
        end else n_pass++;
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            set_in(1'b1, 2'd0, WIDTH'(i + 100), 4'b0001, 1'b1);
            n_checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL stream in_ready cyc%0d: got %b want 1", i, in_ready);
            end else n_pass++;
            tick();
            n_checks++;
            if (out1 !== WIDTH'(i + 100) || out_valid[0] !== 1'b1) begin
                $display("FAIL stream out1 cyc%0d: got %h/%b want %h/1", i, out1, out_valid[0], i + 100);
            end else n_pass++;
        end
        n_checks++;
        if (cnt1 !== 8'd43) begin
            $display("FAIL stream cnt1 wrap: got %0d want 43", cnt1);
        end else n_pass++;
        set_in(1'b0, 2'd0, '0, 4'b0001, 1'b1);
        tick();
        n_checks++;
        if (cnt1 !== 8'd44 || out_valid[0] !== 1'b0) begin
            $display("FAIL stream drain: cnt1=%0d valid=%b want 44/0", cnt1, out_valid[0]);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1'b1, 2'd1, 32'h22, 4'b0000, 1'b1);
        tick();
        set_in(1'b1, 2'd3, 32'h44, 4'b0000, 1'b1);
        tick();
        n_checks++;
        if (out_valid !== 4'b1010) begin
            $display("FAIL rstmid setup: out_valid=%b want 1010", out_valid);
        end else n_pass++;
        // Reset coincides with an in_fire and two port fires.
        set_in(1'b1, 2'd0, 32'h99, 4'b1111, 1'b0);
        tick();
        set_in(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        n_checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || out2 !== '0 || out4 !== '0 || out1 !== '0) begin
            $display("FAIL rstmid state: valid=%b busy=%b out1=%h out2=%h out4=%h want 0", out_valid, busy, out1, out2, out4);
        end else n_pass++;
        n_checks++;
        if ({cnt1, cnt2, cnt3, cnt4} !== '0) begin
            $display("FAIL rstmid cnt: %0d %0d %0d %0d want 0", cnt1, cnt2, cnt3, cnt4);
        end else n_pass++;
    endtask

    task automatic test_random();
        bit exp_rdy;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom % 4) != 0, 2'($urandom_range(0, 3)), $urandom,
                   4'($urandom), ($urandom % 60) != 0);
            exp_rdy = !m_full[control] || out_ready[control];
            n_checks++;
            if (in_ready !== exp_rdy) begin
                $display("FAIL rand in_ready cyc%0d: got %b want %b", i, in_ready, exp_rdy);
            end else n_pass++;
            tick();
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (out_valid[k] !== m_full[k] || dcnt[k] !== CNTW'(m_cnt[k]) ||
                    (m_full[k] && dout[k] !== m_data[k])) begin
                    $display("FAIL rand port%0d cyc%0d: valid=%b cnt=%0d data=%h want %b/%0d/%h",
                             k + 1, i, out_valid[k], dcnt[k], dout[k], m_full[k], CNTW'(m_cnt[k]), m_data[k]);
                end else n_pass++;
            end
            n_checks++;
            if (busy !== (m_full[0] | m_full[1] | m_full[2] | m_full[3])) begin
                $display("FAIL rand busy cyc%0d: got %b", i, busy);
            end else n_pass++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        control   = 2'd0;
        indata    = '0;
        out_ready = 4'b0000;
        @(posedge clk);
        #1;
        test_reset();
        test_route();
        test_backpressure();
        test_isolation();
        test_streaming();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
